// File: rtl/alu_multiword_seq_if.sv
// Bus between control/decode, the multi-word sequencer and the 8-bit ALU.
// The master side is the control logic plus the ALU; the slave side is the sequencer.
interface alu_multiword_seq_if #(
    parameter int unsigned WORDS = 2
);
    localparam int unsigned W = 8 * WORDS;

    logic         start;
    logic [1:0]   op_sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [7:0]   alu_out;
    logic         alu_cout;
    logic [3:0]   alu_op;
    logic [1:0]   alu_funct;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic [1:0]   alu_imm;
    logic         alu_cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;

    modport master (
        output start, op_sel, a, b, alu_out, alu_cout,
        input  alu_op, alu_funct, alu_a, alu_b, alu_imm, alu_cin,
        input  busy, done, result, carry
    );

    modport slave (
        input  start, op_sel, a, b, alu_out, alu_cout,
        output alu_op, alu_funct, alu_a, alu_b, alu_imm, alu_cin,
        output busy, done, result, carry
    );
endinterface

// File: rtl/alu_multiword_seq.sv
// Sequences WORDS-byte add/sub/shl/shr through an 8-bit combinational ALU,
// one byte per cycle, chaining the ALU carry through an internal register.
module alu_multiword_seq #(
    parameter int unsigned WORDS = 2
) (
    input  logic                Clk,
    input  logic                Reset_n,
    alu_multiword_seq_if.slave  bus
);
    localparam int unsigned W  = 8 * WORDS;
    localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [1:0]      op_q;
    logic [CW-1:0]   cnt;
    logic            cy_q;
    logic [W-1:0]    result_q;
    logic            busy_q;
    logic            done_q;

    logic [CW-1:0]   idx;
    logic            first;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [3:0]      alu_op_c;
    logic [1:0]      alu_funct_c;
    logic [7:0]      alu_a_c;
    logic [7:0]      alu_b_c;
    logic            alu_cin_c;

    // Byte select: shift-right walks MSB first, everything else LSB first
    always_comb begin
        idx    = (op_q == 2'b11) ? (LAST - cnt) : cnt;
        first  = (cnt == '0);
        a_byte = a_q[8*idx +: 8];
        b_byte = b_q[8*idx +: 8];
    end

    // ALU drive; quiescent (ALU default path) outside EXEC
    always_comb begin
        alu_op_c    = 4'b0000;
        alu_funct_c = 2'b00;
        alu_a_c     = 8'h00;
        alu_b_c     = 8'h00;
        alu_cin_c   = 1'b0;
        if (state == EXEC) begin
            alu_cin_c = cy_q;
            case (op_q)
                2'b00: begin
                    alu_op_c    = 4'b0100;
                    alu_funct_c = first ? 2'b00 : 2'b01;
                    alu_a_c     = a_byte;
                    alu_b_c     = b_byte;
                end
                2'b01: begin
                    // ALU computes InputB - InputA, so operands are swapped
                    alu_op_c    = 4'b0100;
                    alu_funct_c = first ? 2'b10 : 2'b11;
                    alu_a_c     = b_byte;
                    alu_b_c     = a_byte;
                end
                2'b10: begin
                    alu_op_c    = 4'b1100;
                    alu_funct_c = 2'b00;
                    alu_b_c     = a_byte;
                end
                default: begin
                    alu_op_c    = 4'b1100;
                    alu_funct_c = 2'b01;
                    alu_b_c     = a_byte;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            cnt      <= '0;
            cy_q     <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        op_q     <= bus.op_sel;
                        cnt      <= '0;
                        cy_q     <= 1'b0;
                        result_q <= '0;
                        busy_q   <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    result_q[8*idx +: 8] <= bus.alu_out;
                    cy_q                 <= bus.alu_cout;
                    if (cnt == LAST) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_op    = alu_op_c;
    assign bus.alu_funct = alu_funct_c;
    assign bus.alu_a     = alu_a_c;
    assign bus.alu_b     = alu_b_c;
    assign bus.alu_cin   = alu_cin_c;
    assign bus.alu_imm   = 2'b00;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry     = cy_q;
endmodule

// File: tb/tb_alu_multiword_seq.sv
// Directed self-checking bench for alu_multiword_seq (WORDS=2) with a behavioural 8-bit ALU.
module tb_alu_multiword_seq;
    localparam int unsigned WORDS = 2;
    localparam int unsigned W     = 8 * WORDS;

    logic Clk;
    logic Reset_n;
    int   checks;
    int   failures;

    alu_multiword_seq_if #(.WORDS(WORDS)) bus ();

    alu_multiword_seq #(.WORDS(WORDS)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural ALU: add/adc, B-A with borrow, shl/shr through carry
    logic [8:0] alu_t;
    always_comb begin
        alu_t = 9'h000;
        case ({bus.alu_op, bus.alu_funct})
            6'b0100_00: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            6'b0100_01: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'h00, bus.alu_cin};
            6'b0100_10: alu_t = {1'b0, bus.alu_b} - {1'b0, bus.alu_a};
            6'b0100_11: alu_t = {1'b0, bus.alu_b} - {1'b0, bus.alu_a} - {8'h00, bus.alu_cin};
            6'b1100_00: alu_t = {bus.alu_b[7], bus.alu_b[6:0], bus.alu_cin};
            6'b1100_01: alu_t = {bus.alu_b[0], bus.alu_cin, bus.alu_b[7:1]};
            default:    alu_t = 9'h000;
        endcase
        bus.alu_out  = alu_t[7:0];
        bus.alu_cout = alu_t[8];
    end

    // Observations captured by do_op
    logic [W-1:0] res_r;
    logic         cy_r;
    int           edges_r;
    logic         busy_at_done_r;
    logic         done_after_r;
    logic         busy_after_r;
    logic [3:0]   drv_op    [0:1];
    logic [1:0]   drv_funct [0:1];
    logic [7:0]   drv_a     [0:1];
    logic [7:0]   drv_b     [0:1];
    logic         drv_cin   [0:1];

    // Called just after a negedge; returns at the negedge of the first IDLE cycle
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        bit got;
        got         = 1'b0;
        edges_r     = 0;
        bus.op_sel  = op;
        bus.a       = av;
        bus.b       = bv;
        bus.start   = 1'b1;
        while (!got && edges_r < 20) begin
            @(posedge Clk);
            edges_r++;
            @(negedge Clk);
            bus.start = 1'b0;
            if (edges_r <= 2) begin
                drv_op[edges_r-1]    = bus.alu_op;
                drv_funct[edges_r-1] = bus.alu_funct;
                drv_a[edges_r-1]     = bus.alu_a;
                drv_b[edges_r-1]     = bus.alu_b;
                drv_cin[edges_r-1]   = bus.alu_cin;
            end
            if (bus.done === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL op_timeout op=%b a=%h b=%h no done within %0d edges", op, av, bv, edges_r);
        end
        res_r          = bus.result;
        cy_r           = bus.carry;
        busy_at_done_r = bus.busy;
        @(negedge Clk);
        done_after_r = bus.done;
        busy_after_r = bus.busy;
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op_sel = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge Clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h exp=0000", bus.result); end
        checks++; if (bus.carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", bus.carry); end
        checks++; if (bus.alu_op !== 4'b0000 || bus.alu_imm !== 2'b00) begin
            failures++; $display("FAIL reset_alu_drive op=%b imm=%b exp op=0000 imm=00", bus.alu_op, bus.alu_imm);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_add();
        do_op(2'b00, 16'h12FF, 16'h0001);
        checks++; if (res_r !== 16'h1300) begin failures++; $display("FAIL add1_result got=%h exp=1300", res_r); end
        checks++; if (cy_r !== 1'b0) begin failures++; $display("FAIL add1_carry got=%b exp=0", cy_r); end
        checks++; if (edges_r != 3) begin failures++; $display("FAIL add1_latency got=%0d exp=3", edges_r); end
        checks++; if (done_after_r !== 1'b0 || busy_after_r !== 1'b0) begin
            failures++; $display("FAIL add1_done_width done=%b busy=%b exp 0 0", done_after_r, busy_after_r);
        end
        checks++; if (busy_at_done_r !== 1'b1) begin failures++; $display("FAIL add1_busy_in_done got=%b exp=1", busy_at_done_r); end
        checks++; if (drv_op[0] !== 4'b0100 || drv_funct[0] !== 2'b00 || drv_a[0] !== 8'hFF || drv_b[0] !== 8'h01) begin
            failures++; $display("FAIL add1_k0_drive op=%b f=%b a=%h b=%h exp 0100 00 ff 01", drv_op[0], drv_funct[0], drv_a[0], drv_b[0]);
        end
        checks++; if (drv_funct[1] !== 2'b01 || drv_cin[1] !== 1'b1 || drv_a[1] !== 8'h12) begin
            failures++; $display("FAIL add1_k1_drive f=%b cin=%b a=%h exp 01 1 12", drv_funct[1], drv_cin[1], drv_a[1]);
        end
        do_op(2'b00, 16'hFFFF, 16'h0001);
        checks++; if (res_r !== 16'h0000) begin failures++; $display("FAIL add2_result got=%h exp=0000", res_r); end
        checks++; if (cy_r !== 1'b1) begin failures++; $display("FAIL add2_carry got=%b exp=1", cy_r); end
    endtask

    task automatic test_sub();
        do_op(2'b01, 16'h1000, 16'h0001);
        checks++; if (res_r !== 16'h0FFF || cy_r !== 1'b0) begin
            failures++; $display("FAIL sub1 got=%h/%b exp=0fff/0", res_r, cy_r);
        end
        checks++; if (drv_b[0] !== 8'h00 || drv_a[0] !== 8'h01 || drv_funct[0] !== 2'b10) begin
            failures++; $display("FAIL sub1_k0_drive b=%h a=%h f=%b exp 00 01 10", drv_b[0], drv_a[0], drv_funct[0]);
        end
        checks++; if (drv_funct[1] !== 2'b11 || drv_cin[1] !== 1'b1) begin
            failures++; $display("FAIL sub1_k1_drive f=%b cin=%b exp 11 1", drv_funct[1], drv_cin[1]);
        end
        do_op(2'b01, 16'h0000, 16'h0001);
        checks++; if (res_r !== 16'hFFFF || cy_r !== 1'b1) begin
            failures++; $display("FAIL sub2 got=%h/%b exp=ffff/1", res_r, cy_r);
        end
        do_op(2'b01, 16'h1234, 16'h1234);
        checks++; if (res_r !== 16'h0000 || cy_r !== 1'b0) begin
            failures++; $display("FAIL sub3 got=%h/%b exp=0000/0", res_r, cy_r);
        end
    endtask

    task automatic test_shift();
        do_op(2'b10, 16'h80C0, 16'hAAAA);
        checks++; if (res_r !== 16'h0180 || cy_r !== 1'b1) begin
            failures++; $display("FAIL shl got=%h/%b exp=0180/1", res_r, cy_r);
        end
        checks++; if (drv_op[0] !== 4'b1100 || drv_funct[0] !== 2'b00 || drv_b[0] !== 8'hC0 || drv_a[0] !== 8'h00) begin
            failures++; $display("FAIL shl_k0_drive op=%b f=%b b=%h a=%h exp 1100 00 c0 00", drv_op[0], drv_funct[0], drv_b[0], drv_a[0]);
        end
        do_op(2'b11, 16'h0101, 16'h5555);
        checks++; if (res_r !== 16'h0080 || cy_r !== 1'b1) begin
            failures++; $display("FAIL shr1 got=%h/%b exp=0080/1", res_r, cy_r);
        end
        checks++; if (drv_funct[0] !== 2'b01 || drv_cin[1] !== 1'b1) begin
            failures++; $display("FAIL shr1_drive f=%b cin1=%b exp 01 1", drv_funct[0], drv_cin[1]);
        end
        do_op(2'b11, 16'h8001, 16'h0000);
        checks++; if (res_r !== 16'h4000 || cy_r !== 1'b1) begin
            failures++; $display("FAIL shr2 got=%h/%b exp=4000/1", res_r, cy_r);
        end
        checks++; if (drv_b[0] !== 8'h80 || drv_b[1] !== 8'h01) begin
            failures++; $display("FAIL shr2_byte_order b0=%h b1=%h exp 80 01", drv_b[0], drv_b[1]);
        end
    endtask

    task automatic test_ignore_start();
        bus.op_sel = 2'b00; bus.a = 16'h0102; bus.b = 16'h0304; bus.start = 1'b1;
        @(posedge Clk); @(negedge Clk);
        bus.op_sel = 2'b01; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
        @(posedge Clk); @(negedge Clk);
        @(posedge Clk); @(negedge Clk);
        checks++; if (bus.done !== 1'b1 || bus.result !== 16'h0406 || bus.carry !== 1'b0) begin
            failures++; $display("FAIL ignore_exec done=%b result=%h carry=%b exp 1 0406 0", bus.done, bus.result, bus.carry);
        end
        bus.a = 16'h7777; bus.b = 16'h1111;
        @(posedge Clk); @(negedge Clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.result !== 16'h0406) begin
            failures++; $display("FAIL ignore_done busy=%b result=%h exp 0 0406", bus.busy, bus.result);
        end
    endtask

    task automatic test_back_to_back();
        do_op(2'b00, 16'h00F0, 16'h0020);
        checks++; if (res_r !== 16'h0110 || cy_r !== 1'b0) begin
            failures++; $display("FAIL b2b_first got=%h/%b exp=0110/0", res_r, cy_r);
        end
        do_op(2'b01, 16'h0005, 16'h0007);
        checks++; if (edges_r != 3 || res_r !== 16'hFFFE || cy_r !== 1'b1) begin
            failures++; $display("FAIL b2b_second edges=%0d got=%h/%b exp 3 fffe/1", edges_r, res_r, cy_r);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        saw_done  = 1'b0;
        bus.op_sel = 2'b00; bus.a = 16'h1234; bus.b = 16'h0001; bus.start = 1'b1;
        @(posedge Clk); @(negedge Clk);
        bus.start = 1'b0;
        @(posedge Clk); @(negedge Clk);
        checks++; if (bus.busy !== 1'b1 || bus.result !== 16'h0035) begin
            failures++; $display("FAIL mid_progress busy=%b result=%h exp 1 0035", bus.busy, bus.result);
        end
        Reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h0000 || bus.carry !== 1'b0) begin
            failures++; $display("FAIL mid_async_reset busy=%b done=%b result=%h carry=%b exp 0 0 0000 0",
                                 bus.busy, bus.done, bus.result, bus.carry);
        end
        repeat (2) begin
            @(negedge Clk);
            if (bus.done !== 1'b0) saw_done = 1'b1;
        end
        Reset_n = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            if (bus.done !== 1'b0) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin failures++; $display("FAIL mid_no_done got=1 exp=0"); end
        do_op(2'b00, 16'h0102, 16'h0304);
        checks++; if (res_r !== 16'h0406 || cy_r !== 1'b0) begin
            failures++; $display("FAIL post_reset_add got=%h/%b exp=0406/0", res_r, cy_r);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_multiword_seq.md
Name: alu_multiword_seq

Overview:
Multi-cycle sequencer that drives the 8-bit ALU to perform WORDS-byte add, subtract, shift-left-1 and shift-right-1, one byte per cycle.
It chains the ALU carry through an internal carry register.
It sits between the control/decode logic and the ALU, and owns the ALU input bus while busy.
The ALU itself stays combinational and unchanged.

Parameters:
WORDS, 2, operand width in bytes (legal 1..8); operand/result width W = 8*WORDS

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
op_sel  input  2  00 add, 01 sub (a-b), 10 shift left 1, 11 shift right 1
a  input  W  operand A (shift source for 10/11)
b  input  W  operand B (ignored for shifts)
alu_out  input  8  ALU Out
alu_cout  input  1  ALU carry_out
alu_op  output  4  ALU OP
alu_funct  output  2  ALU funct
alu_a  output  8  ALU InputA
alu_b  output  8  ALU InputB
alu_imm  output  2  ALU imm; constant 0
alu_cin  output  1  ALU carry_in
busy  output  1  high in EXEC and DONE
done  output  1  one-cycle pulse in DONE
result  output  W  result; held until the next accepted start
carry  output  1  final carry/borrow/shifted-out bit; held with result

Behaviour:
- Reset (async, Reset_n=0): state=IDLE; result=0, carry=0, busy=0, done=0; operand latches, byte counter and carry register cleared. Reset during EXEC or DONE aborts the operation; no done pulse.
- States: IDLE -> EXEC (start=1) -> DONE (after WORDS EXEC cycles) -> IDLE (unconditionally, next cycle).
- Accept: on a start=1 edge in IDLE, latch a, b, op_sel; clear counter and carry register; clear result to 0. start in EXEC/DONE is ignored (no queueing).
- EXEC processes one byte per cycle, index k = 0..WORDS-1. ALU is driven combinationally from the latches and counter; alu_out/alu_cout are captured at the end of each EXEC cycle into result byte and carry register.
- Byte order:
  - add, sub, shl process LSB first (byte index k).
  - shr processes MSB first (byte index WORDS-1-k).
- add: alu_op=0100; funct=00 for k=0, 01 for k>0; alu_a=a byte, alu_b=b byte; alu_cin = carry register (0 at k=0).
- sub: alu_op=0100; funct=10 for k=0, 11 for k>0. The ALU computes InputB-InputA, so alu_b=a byte and alu_a=b byte. alu_cout=1 means borrow; borrow chains via alu_cin.
- shl: alu_op=1100, funct=00, alu_b=a byte, alu_a=0, alu_cin = carry register (0 at first byte).
- shr: alu_op=1100, funct=01, alu_b=a byte, alu_a=0, alu_cin = carry register (0 at first byte).
- IDLE/DONE ALU drive: alu_op=0000, funct=00, alu_a=alu_b=0, alu_cin=0 (ALU default path: Out=0).
- Timing: start sampled at edge T0. EXEC occupies cycles T0..T0+WORDS-1. done=1 and busy=1 during cycle T0+WORDS. busy=0 from T0+WORDS+1.
- Latency: done is visible WORDS+1 edges after the start edge. Throughput: one operation per WORDS+2 cycles (start is accepted again in the first IDLE cycle).
- Outputs during the operation: result and carry update progressively during EXEC. They are final and stable when done=1 and remain held in IDLE. The carry output equals the carry register.
- Width rules:
  - Arithmetic is modulo 2^W.
  - carry after add = bit W of a+b.
  - carry after sub = 1 iff a<b (unsigned).
  - shl: result = a<<1 modulo 2^W, carry = a[W-1].
  - shr: result = a>>1, carry = a[0].
- WORDS=1: single EXEC cycle; the k=0 rules apply.
- The byte counter saturates conceptually at WORDS-1; no wrap into a second pass.

Test Plan:
1. WORDS=2, add a=0x12FF b=0x0001 -> EXEC k0 drives op=0100 funct=00, k1 drives funct=01 cin=1; result=0x1300, carry=0. done high exactly 2+1 edges after start, one cycle wide.
2. add a=0xFFFF b=0x0001 -> result=0x0000, carry=1. Then sub a=0x1000 b=0x0001 -> alu_b=0x00, alu_a=0x01 at k0; result=0x0FFF, carry=0.
3. sub a=0x0000 b=0x0001 -> result=0xFFFF, carry=1. sub a=0x1234 b=0x1234 -> result=0x0000, carry=0.
4. shl a=0x80C0 -> op=1100 funct=00, LSB first; result=0x0180, carry=1. shr a=0x0101 -> funct=01, MSB byte first; result=0x0080, carry=1.
5. Pulse start again during EXEC and during DONE with different operands -> ignored; first result unchanged. Back-to-back start on the first IDLE cycle is accepted.
6. Drop Reset_n mid-EXEC (k=1) -> busy, done, result, carry go to 0 immediately (async); no done pulse. After release, a new add 0x0102+0x0304 -> result=0x0406, carry=0.
